pipe_stage_ctrl: RTL and testbench

//  Sequencer for the pipeline registers of the segmented RISC-V core; every stage register is a bank of ffD cells.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/load_use_det.sv | 35 +++
 rtl/pipe_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline-register sequencer: controller states,
// the stage write-enable bundle and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // x0 is hard-wired to zero, so a load targeting it can never create a hazard.
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_we_t;

  localparam stage_we_t WE_ALL    = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};
  localparam stage_we_t WE_NONE   = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0};
  // Load-use bubble: hold PC and IF/ID, let the load and everything after it advance.
  localparam stage_we_t WE_BUBBLE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};

endpackage

// File: rtl/load_use_det.sv
// Load-use hazard comparator: flags when the instruction in ID reads a
// register that the load currently in EX has not yet produced.
module load_use_det
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  logic [REG_ADDR_W-1:0] src [2];
  logic [1:0]            uses;
  logic [1:0]            hit;

  assign src[0] = id_rs1;
  assign src[1] = id_rs2;
  assign uses   = {id_uses_rs2, id_uses_rs1};

  // One comparator per source operand; an operand only matters if it is read.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit[gi] = uses[gi] & (src[gi] == ex_rd);
    end
  endgenerate

  assign load_use = ex_mem_read & (ex_rd != REG_ADDR_W'(REG_ZERO)) & (|hit);

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline-register sequencer: drives stage write enables and bubble
// inserts, resolving memory waits, taken branches and load-use stalls,
// with a sticky memory-timeout trap and a saturating stall counter.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_we,
  output logic                   exmem_we,
  output logic                   memwb_we,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   mem_timeout_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // The counter only ever holds 1..MEM_TIMEOUT-1 while waiting.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e                  state_reg, state_next;
  logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
  logic                    err_reg;
  logic [STALL_CNT_W-1:0]  stall_cnt_reg;

  stage_we_t               stage_we;
  logic                    ifid_flush_c, idex_flush_c;
  logic                    serve;
  logic                    load_use;

  load_use_det #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_det (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Next-state and Mealy output decode; "serve" means the memory is not
  // holding the pipe, so branch / load-use / normal advance rules apply.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    serve         = 1'b0;
    stage_we      = WE_NONE;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;

    case (state_reg)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end else begin
          serve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_next = ERR;
          end else begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end else begin
          serve         = 1'b1;
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        // ERR: everything frozen until reset.
      end
    endcase

    if (serve) begin
      if (ex_branch_taken) begin
        stage_we     = WE_ALL;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (load_use) begin
        stage_we     = WE_BUBBLE;
        idex_flush_c = 1'b1;
      end else begin
        stage_we     = WE_ALL;
      end
    end
  end

  // Controller state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_next == ERR) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held (ERR excluded).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg != ERR) && !stage_we.pc && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  // Reset overrides the decoded strobes so no stage register moves while rst is high.
  assign pc_we           = stage_we.pc    & ~rst;
  assign ifid_we         = stage_we.ifid  & ~rst;
  assign idex_we         = stage_we.idex  & ~rst;
  assign exmem_we        = stage_we.exmem & ~rst;
  assign memwb_we        = stage_we.memwb & ~rst;
  assign ifid_flush      = ifid_flush_c   & ~rst;
  assign idex_flush      = idex_flush_c   & ~rst;
  assign mem_timeout_err = err_reg;
  assign stall_cnt       = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: reset, load-use, branch priority,
// memory wait, timeout trap and stall-counter saturation.
module tb_pipe_stage_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;

  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, mem_timeout_err;
  logic [15:0] stall_cnt;

  logic        s_pc_we, s_ifid_we, s_idex_we, s_exmem_we, s_memwb_we;
  logic        s_ifid_flush, s_idex_flush, s_err;
  logic [3:0]  s_stall_cnt;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [4:0] we_v;
  logic [1:0] fl_v;
  assign we_v = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
  assign fl_v = {ifid_flush, idex_flush};

  pipe_stage_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  pipe_stage_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .idex_we(s_idex_we), .exmem_we(s_exmem_we), .memwb_we(s_memwb_we),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .mem_timeout_err(s_err), .stall_cnt(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use_rs1(input logic [4:0] r);
    ex_mem_read = 1'b1; ex_rd = r; id_rs1 = r; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick(); tick();

    // ---- 1: reset, then reset asserted in the middle of a memory wait
    #1;
    check("rst_we", 32'(we_v), 32'h00);
    check("rst_flush", 32'(fl_v), 32'h0);
    rst = 1'b0;
    #1;
    check("run_idle_we", 32'(we_v), 32'h1F);
    check("run_idle_cnt", 32'(stall_cnt), 32'd0);
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    check("memreq_run_we", 32'(we_v), 32'h00);
    tick();
    tick();
    check("midwait_we", 32'(we_v), 32'h00);
    check("midwait_cnt", 32'(stall_cnt), 32'd2);
    rst = 1'b1;
    #1;
    check("async_rst_we", 32'(we_v), 32'h00);
    check("async_rst_err", 32'(mem_timeout_err), 32'd0);
    check("async_rst_cnt", 32'(stall_cnt), 32'd0);
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    check("release_we", 32'(we_v), 32'h1F);
    tick();

    // ---- 2: load-use stall on rs1, x0 ignored, rs2 stall, unused-source no stall
    set_load_use_rs1(5'd5);
    #1;
    check("lu_rs1_we", 32'(we_v), 32'h07);
    check("lu_rs1_flush", 32'(fl_v), 32'h1);
    tick();
    clear_inputs();
    #1;
    check("lu_after_we", 32'(we_v), 32'h1F);
    check("lu_after_flush", 32'(fl_v), 32'h0);
    check("lu_cnt1", 32'(stall_cnt), 32'd1);
    tick();
    set_load_use_rs1(5'd0);
    #1;
    check("lu_x0_we", 32'(we_v), 32'h1F);
    tick();
    check("lu_x0_cnt", 32'(stall_cnt), 32'd1);
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #1;
    check("lu_rs2_we", 32'(we_v), 32'h07);
    tick();
    check("lu_rs2_cnt", 32'(stall_cnt), 32'd2);
    id_uses_rs2 = 1'b0;
    #1;
    check("lu_unused_we", 32'(we_v), 32'h1F);
    tick();
    clear_inputs();

    // ---- 3: branch and load-use in the same cycle -> branch wins
    set_load_use_rs1(5'd9);
    ex_branch_taken = 1'b1;
    #1;
    check("br_lu_we", 32'(we_v), 32'h1F);
    check("br_lu_flush", 32'(fl_v), 32'h3);
    tick();
    clear_inputs();
    check("br_lu_cnt", 32'(stall_cnt), 32'd2);

    // ---- 4: memory wait of 3 cycles, then ready
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_wait%0d_we", i), 32'(we_v), 32'h00);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("mw_ready_we", 32'(we_v), 32'h1F);
    check("mw_ready_flush", 32'(fl_v), 32'h0);
    tick();
    check("mw_cnt", 32'(stall_cnt), 32'd5);
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("mw_back_run_we", 32'(we_v), 32'h1F);
    // pending load-use is served on the memory-release cycle
    mem_req = 1'b1;
    set_load_use_rs1(5'd12);
    #1;
    check("mw_lu_hold_we", 32'(we_v), 32'h00);
    tick();
    mem_ready = 1'b1;
    #1;
    check("mw_lu_rel_we", 32'(we_v), 32'h07);
    check("mw_lu_rel_flush", 32'(fl_v), 32'h1);
    tick();
    clear_inputs();
    #1;
    check("mw_lu_next_we", 32'(we_v), 32'h1F);
    check("mw_lu_cnt", 32'(stall_cnt), 32'd7);
    tick();

    // ---- 5: memory timeout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_15_err", 32'(mem_timeout_err), 32'd0);
    check("to_15_we", 32'(we_v), 32'h00);
    tick();
    check("to_16_err", 32'(mem_timeout_err), 32'd1);
    check("to_16_cnt", 32'(stall_cnt), 32'd16);
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("to_sticky_err", 32'(mem_timeout_err), 32'd1);
    check("to_sticky_we", 32'(we_v), 32'h00);
    check("to_sticky_flush", 32'(fl_v), 32'h0);
    check("to_frozen_cnt", 32'(stall_cnt), 32'd16);
    rst = 1'b1;
    #1;
    check("to_rst_err", 32'(mem_timeout_err), 32'd0);
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    check("to_rel_we", 32'(we_v), 32'h1F);

    // ---- 6: 20 load-use stalls saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      set_load_use_rs1(5'd4);
      tick();
      clear_inputs();
      tick();
    end
    check("sat_narrow_cnt", 32'(s_stall_cnt), 32'd15);
    check("sat_wide_cnt", 32'(stall_cnt), 32'd20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
